regfile_wb_arbiter: RTL
=======================

// Module: regfile_wb_arbiter
// PURPOSE
//  Shares the register file's single write port (WE3/A3/WD3) between two writeback requesters.
//  req0 is the ALU/immediate path; req1 is the load/memory path.
//  Accepted writes are captured in a one-entry registered stage that drives the write port the next cycle.
//  The stage is also exported as a forwarding tap so readers can bypass a write that is not yet committed.
// PARAMETERS
//  DATA_WIDTH  32  width of write data, matching the register file
//  ADDR_WIDTH  5   register address width (32 registers)
// PORTS
//  clk         in   1           rising-edge clock, shared with the register file
//  rst         in   1           synchronous active-high reset
//  stall       in   1           pipeline freeze; blocks all grants while high
//  req0_valid  in   1           requester 0 has a write
//  req0_addr   in   ADDR_WIDTH  destination register (rd) of requester 0
//  req0_data   in   DATA_WIDTH  write data of requester 0
//  req0_ready  out  1           requester 0 write accepted this cycle
//  req1_valid  in   1           requester 1 has a write
//  req1_addr   in   ADDR_WIDTH  destination register (rd) of requester 1
//  req1_data   in   DATA_WIDTH  write data of requester 1
//  req1_ready  out  1           requester 1 write accepted this cycle
//  WE3         out  1           register file write enable (registered)
//  A3          out  ADDR_WIDTH  register file write address (registered)
//  WD3         out  DATA_WIDTH  register file write data (registered)
//  fwd_valid   out  1           equals WE3; the tap holds a write not yet committed
//  fwd_addr    out  ADDR_WIDTH  equals A3
//  fwd_data    out  DATA_WIDTH  equals WD3
// BEHAVIOUR
//  Reset: WE3=0, A3=0, WD3=0, rr_last=1 (req0 wins the first contention).
//   - Reset mid-operation discards any staged write; no write reaches the register file that cycle.
//  Grant (combinational, from current inputs and rr_last):
//   - stall=1 -> both readys 0.
//   - Only one valid -> that requester is granted.
//   - Both valid -> the requester that is not rr_last is granted.
//   - reqN_ready = grantN. A handshake is reqN_valid & reqN_ready.
//   - Requesters hold valid/addr/data stable until ready; ready never depends on ready.
//  rr_last updates to the granted index only on a contention cycle (both valid, not stalled).
//  Stage: on a handshake in cycle N, the captured addr/data appear on A3/WD3 in cycle N+1.
//   - The register file commits at the end of cycle N+1, so latency from handshake to architectural
//     update is 1 cycle.
//   - WE3 in cycle N+1 = handshake & (addr != 0). Writes to x0 are accepted (ready=1) but dropped.
//  No handshake in cycle N -> WE3=0 in cycle N+1; A3/WD3 hold their last values.
//  The stage drains every cycle, so there is no backpressure from the register file and sustained
//  throughput is 1 write per cycle.
//  Both requesters targeting the same rd in the same cycle: only the granted one is written.
//   - The loser is written in a later cycle, so the loser's data is the final value.
//  stall rising while the stage is full: the staged write still commits (stall gates grants only).
//  Address and data pass through without arithmetic or width change.
// STRUCTURE
//  Package regfile_pkg:
//   - REG_ADDR_W=5, NUM_REGS=32, ZERO_REG=5'd0
//   - typedef wb_req_t {addr, data}
//  Sub-module rr_arbiter2: 2-way round-robin with a 1-bit rr_last register, enable (=~stall), and
//  one-hot grant. The top level holds the mux and the registered stage.
// TESTING
//  1. rst for 2 cycles, then release -> WE3=0, A3=0, WD3=0, both readys 0 with no valid.
//  2. req0 valid, addr=5, data=0xDEADBEEF, cycle N -> req0_ready=1 in N; WE3=1, A3=5, WD3=0xDEADBEEF in N+1;
//     a register file read of x5 returns 0xDEADBEEF in N+2.
//  3. Both valid for 4 cycles, addr 1 and 2 -> grants alternate req0,req1,req0,req1;
//     A3 sequence 1,2,1,2 in the following cycles.
//  4. req1 valid, addr=0, data=0x1234 -> req1_ready=1; WE3=0 next cycle; x0 is still 0.
//  5. stall=1 with both valid -> readys 0 and WE3=0 the next cycle; deassert -> req0 is granted first.
//  6. Handshake in cycle N, rst=1 in N+1 -> WE3=0 in N+1 and the target register is unchanged.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared register-file writeback types and constants.
// Imported by the writeback arbiter and its round-robin sub-block.
package regfile_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned NUM_REGS   = 32;
    localparam int unsigned XLEN       = 32;

    localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

    // Requester index: 0 is the ALU/immediate path, 1 is the load/memory path.
    typedef enum logic {
        REQ_ALU = 1'b0,
        REQ_MEM = 1'b1
    } wb_src_e;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [XLEN-1:0]       data;
    } wb_req_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter with a one-hot grant.
// The requester granted on the last contended cycle loses the next contention.
module rr_arbiter2
    import regfile_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    wb_src_e rr_last_q;
    wb_src_e rr_last_d;

    always_comb begin
        gnt       = '0;
        rr_last_d = rr_last_q;
        if (en) begin
            if (req[0] && req[1]) begin
                // Priority only moves when there is actual contention.
                if (rr_last_q == REQ_MEM) begin
                    gnt[0]    = 1'b1;
                    rr_last_d = REQ_ALU;
                end else begin
                    gnt[1]    = 1'b1;
                    rr_last_d = REQ_MEM;
                end
            end else begin
                gnt = req;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_last_q <= REQ_MEM;
        end else begin
            rr_last_q <= rr_last_d;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates two writeback requesters onto the register file's single write port
// through a one-entry registered stage that doubles as a forwarding tap.
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall,
    input  logic                  req0_valid,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    input  logic [DATA_WIDTH-1:0] req0_data,
    output logic                  req0_ready,
    input  logic                  req1_valid,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    input  logic [DATA_WIDTH-1:0] req1_data,
    output logic                  req1_ready,
    output logic                  WE3,
    output logic [ADDR_WIDTH-1:0] A3,
    output logic [DATA_WIDTH-1:0] WD3,
    output logic                  fwd_valid,
    output logic [ADDR_WIDTH-1:0] fwd_addr,
    output logic [DATA_WIDTH-1:0] fwd_data
);

    logic [1:0]            gnt;
    logic                  arb_en;
    logic                  hs;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_data;

    logic                  we_q,   we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;

    // Nothing is accepted during reset, since the stage would discard it anyway.
    assign arb_en = ~stall & ~rst;

    rr_arbiter2 u_arb (
        .clk (clk),
        .rst (rst),
        .en  (arb_en),
        .req ({req1_valid, req0_valid}),
        .gnt (gnt)
    );

    assign req0_ready = gnt[0];
    assign req1_ready = gnt[1];

    always_comb begin
        hs       = gnt[0] | gnt[1];
        sel_addr = gnt[1] ? req1_addr : req0_addr;
        sel_data = gnt[1] ? req1_data : req0_data;

        we_d   = hs && (sel_addr != ADDR_WIDTH'(ZERO_REG));
        addr_d = addr_q;
        data_d = data_q;
        if (hs) begin
            addr_d = sel_addr;
            data_d = sel_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            we_q   <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
        end else begin
            we_q   <= we_d;
            addr_q <= addr_d;
            data_q <= data_d;
        end
    end

    // A staged write must not commit in the cycle reset arrives.
    assign WE3       = we_q & ~rst;
    assign A3        = addr_q;
    assign WD3       = data_q;
    assign fwd_valid = WE3;
    assign fwd_addr  = addr_q;
    assign fwd_data  = data_q;

endmodule
